// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 key decoder.
// Filter option: define PS2_TYPEMATIC_FILTER_EN to drop repeated makes.
package ps2_pkg;

    localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

    typedef struct packed {
        logic       ext;
        logic       rel;
        logic [7:0] code;
    } ps2_event_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } ps2_dec_state_t;

    // Odd parity holds when data plus parity bit carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Key-event stream: the decoder is the master, the consumer the slave.
interface ps2_key_decoder_if;
    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_release;

    modport master (output ev_valid, ev_code, ev_ext, ev_release, input ev_ready);
    modport slave  (input ev_valid, ev_code, ev_ext, ev_release, output ev_ready);
endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronisers, 11-bit framing with start/parity/stop
// checks, and a watchdog that abandons a stalled partial frame.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES = 3,
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-2:0] r_data_sync;
    logic [3:0]             r_bit_cnt;
    logic [10:0]            r_frame;
    logic                   r_done;
    logic [TW-1:0]          r_tmo;
    logic                   w_fall;
    logic                   w_timeout;
    logic                   w_frame_ok;

    assign w_fall     = r_clk_sync[SYNC_STAGES-1] & ~r_clk_sync[SYNC_STAGES-2];
    assign w_timeout  = (r_bit_cnt != 4'd0) && !w_fall && (r_tmo == TW'(TIMEOUT_CYC - 1));
    assign w_frame_ok = ~r_frame[0] & r_frame[10] & odd_parity_ok(r_frame[8:1], r_frame[9]);

    // Synchronisers, bit capture, watchdog and registered result pulses.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_clk_sync   <= '1;
            r_data_sync  <= '1;
            r_bit_cnt    <= 4'd0;
            r_frame      <= 11'd0;
            r_done       <= 1'b0;
            r_tmo        <= '0;
            o_byte       <= 8'd0;
            o_byte_valid <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            r_clk_sync[0]  <= i_ps2_clk;
            r_data_sync[0] <= i_ps2_data;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_clk_sync[k] <= r_clk_sync[k-1];
            end
            for (int k = 1; k < SYNC_STAGES - 1; k++) begin
                r_data_sync[k] <= r_data_sync[k-1];
            end
            r_done <= 1'b0;
            if (w_fall) begin
                r_frame[r_bit_cnt] <= r_data_sync[SYNC_STAGES-2];
                r_tmo              <= '0;
                if (r_bit_cnt == 4'd10) begin
                    r_bit_cnt <= 4'd0;
                    r_done    <= 1'b1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end
            end else if (w_timeout) begin
                r_bit_cnt <= 4'd0;
                r_tmo     <= '0;
            end else if (r_bit_cnt != 4'd0) begin
                r_tmo <= r_tmo + TW'(1);
            end else begin
                r_tmo <= '0;
            end
            if (r_done) begin
                o_byte <= r_frame[8:1];
            end else begin
                o_byte <= o_byte;
            end
            o_byte_valid <= r_done & w_frame_ok;
            o_frame_err  <= (r_done & ~w_frame_ok) | w_timeout;
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 key decoder: frame receiver, E0/F0 prefix FSM and event FIFO.
// Define PS2_TYPEMATIC_FILTER_EN to suppress repeated makes of the same key.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES = 3,
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 5000,
    parameter int CNT_W       = 8
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          i_ps2_clk,
    input  logic                          i_ps2_data,
    ps2_key_decoder_if.master             ev_if,
    output logic                          o_frame_err,
    output logic                          o_overflow,
    input  logic                          i_clr_ovf,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic [CNT_W-1:0]              o_make_count
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0]     w_byte;
    logic           w_byte_valid;
    logic           w_frame_err;
    ps2_dec_state_t r_state, w_state_nxt;
    logic           w_emit;
    ps2_event_t     w_ev;
    logic           w_push;

    ps2_frame_rx #(
        .SYNC_STAGES (SYNC_STAGES),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .clk          (clk),
        .resetn       (resetn),
        .i_ps2_clk    (i_ps2_clk),
        .i_ps2_data   (i_ps2_data),
        .o_byte       (w_byte),
        .o_byte_valid (w_byte_valid),
        .o_frame_err  (w_frame_err)
    );

    assign o_frame_err = w_frame_err;

    // Prefix decoder state register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Prefix decoder next state and event emission.
    always_comb begin
        w_state_nxt = r_state;
        w_emit      = 1'b0;
        w_ev        = '{ext: 1'b0, rel: 1'b0, code: w_byte};
        if (w_frame_err) begin
            w_state_nxt = IDLE;
        end else if (w_byte_valid) begin
            if (w_byte == PS2_PFX_EXT) begin
                w_state_nxt = EXT;
            end else if (w_byte == PS2_PFX_BRK) begin
                case (r_state)
                    IDLE, BRK:    w_state_nxt = BRK;
                    EXT, EXT_BRK: w_state_nxt = EXT_BRK;
                    default:      w_state_nxt = IDLE;
                endcase
            end else begin
                w_emit      = 1'b1;
                w_ev.ext    = (r_state == EXT) || (r_state == EXT_BRK);
                w_ev.rel    = (r_state == BRK) || (r_state == EXT_BRK);
                w_state_nxt = IDLE;
            end
        end else begin
            w_state_nxt = r_state;
        end
    end

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic       r_last_valid;
    logic       r_last_ext;
    logic [7:0] r_last_code;
    logic       w_match;

    assign w_match = r_last_valid && (r_last_ext == w_ev.ext) && (r_last_code == w_ev.code);
    assign w_push  = w_emit & ~(w_match & ~w_ev.rel);

    // Last held make; a repeat of it is the keyboard's typematic auto-repeat.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_last_valid <= 1'b0;
            r_last_ext   <= 1'b0;
            r_last_code  <= 8'd0;
        end else if (w_frame_err) begin
            r_last_valid <= 1'b0;
        end else if (w_emit && w_ev.rel) begin
            r_last_valid <= w_match ? 1'b0 : r_last_valid;
        end else if (w_emit && !w_match) begin
            r_last_valid <= 1'b1;
            r_last_ext   <= w_ev.ext;
            r_last_code  <= w_ev.code;
        end else begin
            r_last_valid <= r_last_valid;
        end
    end
`else
    assign w_push = w_emit;
`endif

    ps2_event_t       r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_ovf;
    logic [CNT_W-1:0] r_make_cnt;
    logic             w_empty, w_full, w_pop, w_wr, w_drop;
    ps2_event_t       w_head;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_pop   = ~w_empty & ev_if.ev_ready;
    assign w_wr    = w_push & (~w_full | w_pop);
    assign w_drop  = w_push & w_full & ~w_pop;
    assign w_head  = r_mem[r_rd_ptr];

    // Event storage; contents need no reset since occupancy gates the head.
    always_ff @(posedge clk) begin
        if (resetn && w_wr) begin
            r_mem[r_wr_ptr] <= w_ev;
        end
    end

    // Pointers, occupancy, sticky overflow and make counter.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_ovf      <= 1'b0;
            r_make_cnt <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (i_clr_ovf) begin
                r_ovf <= 1'b0;
            end
            if (w_wr && !w_ev.rel) begin
                r_make_cnt <= r_make_cnt + CNT_W'(1);
            end
        end
    end

    // Head of queue presented directly; zeros while empty.
    always_comb begin
        ev_if.ev_valid   = ~w_empty;
        ev_if.ev_code    = 8'd0;
        ev_if.ev_ext     = 1'b0;
        ev_if.ev_release = 1'b0;
        if (!w_empty) begin
            ev_if.ev_code    = w_head.code;
            ev_if.ev_ext     = w_head.ext;
            ev_if.ev_release = w_head.rel;
        end else begin
            ev_if.ev_code    = 8'd0;
        end
    end

    assign o_overflow   = r_ovf;
    assign o_fifo_level = r_count;
    assign o_make_count = r_make_cnt;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder against a queue-based event model.
module tb_ps2_key_decoder;
    import ps2_pkg::*;

    localparam int SS = 3;
    localparam int FD = 8;
    localparam int TO = 100;
    localparam int CW = 8;
    localparam int H  = 8;

    logic clk = 1'b0, resetn = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1, clr_ovf = 1'b0;
    logic frame_err, overflow;
    logic [3:0] level;
    logic [CW-1:0] mcount;

    ps2_key_decoder_if ev_if();

    ps2_key_decoder #(.SYNC_STAGES(SS), .FIFO_DEPTH(FD), .TIMEOUT_CYC(TO), .CNT_W(CW)) dut (
        .clk(clk), .resetn(resetn), .i_ps2_clk(ps2_clk), .i_ps2_data(ps2_data),
        .ev_if(ev_if), .o_frame_err(frame_err), .o_overflow(overflow),
        .i_clr_ovf(clr_ovf), .o_fifo_level(level), .o_make_count(mcount)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0, err_cnt = 0, e0;
    bit chk_en = 1'b0;

    logic [9:0] exp_q[$];
    bit         m_ext, m_brk, m_ovf, m_lv, m_lext;
    logic [7:0] m_mcnt, m_lcode;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) if (resetn && frame_err === 1'b1) err_cnt++;

    always @(negedge clk) begin : cmp
        logic [9:0] h;
        if (chk_en) begin
            h = (exp_q.size() != 0) ? exp_q[0] : 10'h000;
            check("outputs",
                  {8'h00, ev_if.ev_valid, ev_if.ev_ext, ev_if.ev_release, ev_if.ev_code, level, mcount, overflow},
                  {8'h00, exp_q.size() != 0, h[9], h[8], h[7:0], 4'(exp_q.size()), m_mcnt, m_ovf});
        end
    end

    task automatic model_push(input logic [9:0] e);
`ifdef PS2_TYPEMATIC_FILTER_EN
        bit match;
        match = m_lv && (m_lext == e[9]) && (m_lcode == e[7:0]);
        if (e[8]) begin
            if (match) m_lv = 1'b0;
        end else begin
            if (match) return;
            m_lv = 1'b1; m_lext = e[9]; m_lcode = e[7:0];
        end
`endif
        if (exp_q.size() == FD) m_ovf = 1'b1;
        else begin
            exp_q.push_back(e);
            if (!e[8]) m_mcnt++;
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (b == 8'hE0) begin m_ext = 1'b1; m_brk = 1'b0; end
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin model_push({m_ext, m_brk, b}); m_ext = 1'b0; m_brk = 1'b0; end
    endtask

    task automatic model_err();
        m_ext = 1'b0; m_brk = 1'b0; m_lv = 1'b0;
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_ovf = 1'b0; m_mcnt = 8'd0;
        model_err();
    endtask

    function automatic logic [10:0] mk(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        return {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    // mode 1: check ev_valid latency after the stop edge; mode 2: pop during the write cycle.
    task automatic ps2_bits(input logic [10:0] bits, input int nbits, input int mode);
        for (int i = 0; i < nbits; i++) begin
            @(posedge clk); #1 ps2_data = bits[i];
            repeat (H) @(posedge clk);
            #1 ps2_clk = 1'b0;
            if (i == 10 && mode == 1) begin
                repeat (4) @(posedge clk);
                @(negedge clk) check("lat_before", ev_if.ev_valid, 0);
                @(posedge clk);
                @(negedge clk) check("lat_at", ev_if.ev_valid, 1);
            end
            if (i == 10 && mode == 2) begin
                repeat (4) @(posedge clk);
                #1 ev_if.ev_ready = 1'b1;
                @(posedge clk); #1 ev_if.ev_ready = 1'b0;
            end
            repeat (H) @(posedge clk);
            #1 ps2_clk = 1'b1;
        end
        @(posedge clk); #1 ps2_data = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        chk_en = 1'b0;
        ps2_bits(mk(b, 1'b0, 1'b0), 11, 0);
        model_byte(b);
        @(posedge clk); #1 chk_en = 1'b1;
    endtask

    task automatic pop();
        @(posedge clk); #1 ev_if.ev_ready = 1'b1;
        @(posedge clk); #1 ev_if.ev_ready = 1'b0;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
    endtask

    task automatic drain();
        while (exp_q.size() != 0) pop();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        ev_if.ev_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        check("rst_valid", ev_if.ev_valid, 0);
        check("rst_level", level, 0);
        check("rst_mcount", mcount, 0);
        check("rst_ovf", overflow, 0);
        @(posedge clk); #1 chk_en = 1'b1;

        // single make with latency check
        chk_en = 1'b0;
        ps2_bits(mk(8'h1C, 1'b0, 1'b0), 11, 1);
        model_byte(8'h1C);
        @(posedge clk); #1 chk_en = 1'b1;
        @(negedge clk);
        check("t1_head", {ev_if.ev_ext, ev_if.ev_release, ev_if.ev_code}, 10'h01C);
        check("t1_mcount", mcount, 1);
        pop();

        send(8'hF0); send(8'h1C);
        @(negedge clk) check("brk_head", {ev_if.ev_ext, ev_if.ev_release, ev_if.ev_code}, 10'h11C);
        pop();
        send(8'hE0); send(8'hF0); send(8'h75);
        @(negedge clk) check("extbrk_head", {ev_if.ev_ext, ev_if.ev_release, ev_if.ev_code}, 10'h375);
        check("brk_mcount", mcount, 1);
        pop();

        // parity error, stop error, timeout
        e0 = err_cnt;
        chk_en = 1'b0;
        ps2_bits(mk(8'h1C, 1'b1, 1'b0), 11, 0);
        model_err();
        @(posedge clk); #1 chk_en = 1'b1;
        check("par_err", err_cnt, e0 + 1);
        chk_en = 1'b0;
        ps2_bits(mk(8'h1C, 1'b0, 1'b1), 11, 0);
        model_err();
        @(posedge clk); #1 chk_en = 1'b1;
        check("stop_err", err_cnt, e0 + 2);
        check("err_level", level, 0);
        chk_en = 1'b0;
        ps2_bits(mk(8'h32, 1'b0, 1'b0), 5, 0);
        repeat (TO + 20) @(posedge clk);
        #1 model_err();
        chk_en = 1'b1;
        check("tmo_err", err_cnt, e0 + 3);
        send(8'h32);
        @(negedge clk) check("post_tmo_head", {ev_if.ev_ext, ev_if.ev_release, ev_if.ev_code}, 10'h032);
        check("post_tmo_mcount", mcount, 2);
        pop();

        // overflow
        for (int i = 0; i <= FD; i++) send(8'h15 + 8'(i));
        @(negedge clk);
        check("ovf_level", level, FD);
        check("ovf_flag", overflow, 1);
        check("ovf_mcount", mcount, 2 + FD);
        @(posedge clk); #1 clr_ovf = 1'b1;
        @(posedge clk); #1 clr_ovf = 1'b0;
        m_ovf = 1'b0;
        @(negedge clk) check("clr_ovf", overflow, 0);
        chk_en = 1'b0;
        ps2_bits(mk(8'h40, 1'b0, 1'b0), 11, 2);
        void'(exp_q.pop_front());
        model_byte(8'h40);
        @(posedge clk); #1 chk_en = 1'b1;
        @(negedge clk);
        check("full_pp_level", level, FD);
        check("full_pp_ovf", overflow, 0);
        check("full_pp_head", ev_if.ev_code, 8'h16);
        check("full_pp_mcount", mcount, 3 + FD);
        drain();

        // typematic repeats
        send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C);
        @(negedge clk);
`ifdef PS2_TYPEMATIC_FILTER_EN
        check("rep_level", level, 3);
        check("rep_mcount", mcount, 5 + FD);
`else
        check("rep_level", level, 5);
        check("rep_mcount", mcount, 7 + FD);
`endif
        drain();

        // reset in the middle of a frame
        send(8'h11);
        e0 = err_cnt;
        chk_en = 1'b0;
        ps2_bits(mk(8'h2A, 1'b0, 1'b0), 5, 0);
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        model_reset();
        @(negedge clk);
        check("mid_rst_valid", ev_if.ev_valid, 0);
        check("mid_rst_level", level, 0);
        check("mid_rst_mcount", mcount, 0);
        @(posedge clk); #1 chk_en = 1'b1;
        repeat (TO + 20) @(posedge clk);
        check("mid_rst_noerr", err_cnt, e0);
        send(8'h2A);
        @(negedge clk) check("mid_rst_head", {ev_if.ev_ext, ev_if.ev_release, ev_if.ev_code}, 10'h02A);
        check("mid_rst_mcount1", mcount, 1);
        pop();
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
